// File: rtl/wb_pkg.sv
// Shared types for the writeback stage: result-source select, load funct3
// encodings, FSM states and the load alignment/legality rule.
package wb_pkg;

  typedef enum logic [1:0] {
    WB_ALU  = 2'd0,
    WB_LOAD = 2'd1,
    WB_PC4  = 2'd2,
    WB_IMM  = 2'd3
  } wb_sel_e;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_MEM = 2'd1,
    COMMIT   = 2'd2
  } wb_state_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // A load may proceed only if funct3 is a real load width and the address
  // is naturally aligned for that width.
  function automatic logic load_ok(input logic [2:0] f3, input logic [1:0] lo);
    logic ok;
    ok = 1'b0;
    case (f3)
      F3_LB, F3_LBU: ok = 1'b1;
      F3_LH, F3_LHU: ok = ~lo[0];
      F3_LW:         ok = (lo == 2'b00);
      default:       ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/wb_unit_if.sv
// Execute -> writeback handshake, memory read return and register file
// write port bundled together. slave is the writeback unit, master the
// surrounding pipeline (or a testbench).
interface wb_if;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rd_addr;
  logic [1:0]  in_wb_sel;
  logic [2:0]  in_funct3;
  logic [31:0] in_alu_result;
  logic [31:0] in_pc_plus4;
  logic [31:0] in_imm;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        reg_write;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;
  logic        load_fault;

  modport slave (
    input  in_valid, in_rd_addr, in_wb_sel, in_funct3, in_alu_result,
           in_pc_plus4, in_imm, mem_rvalid, mem_rdata,
    output in_ready, reg_write, rd_addr, rd_data, load_fault
  );

  modport master (
    output in_valid, in_rd_addr, in_wb_sel, in_funct3, in_alu_result,
           in_pc_plus4, in_imm, mem_rvalid, mem_rdata,
    input  in_ready, reg_write, rd_addr, rd_data, load_fault
  );
endinterface

// File: rtl/wb_unit_load_extract.sv
// Picks the addressed byte/halfword out of an aligned memory word and
// sign- or zero-extends it according to the load funct3.
module load_extract
  import wb_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_word,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Lane select: byte by addr[1:0], halfword by addr[1].
  always_comb begin
    w_byte = i_word[7:0];
    case (i_addr_lo)
      2'd0: w_byte = i_word[7:0];
      2'd1: w_byte = i_word[15:8];
      2'd2: w_byte = i_word[23:16];
      2'd3: w_byte = i_word[31:24];
      default: w_byte = i_word[7:0];
    endcase
    w_half = i_addr_lo[1] ? i_word[31:16] : i_word[15:0];
  end

  // Extension by width and signedness; lw (and anything else) passes the word.
  always_comb begin
    o_data = i_word;
    case (i_funct3)
      F3_LB:   o_data = {{24{w_byte[7]}}, w_byte};
      F3_LBU:  o_data = {24'd0, w_byte};
      F3_LH:   o_data = {{16{w_half[15]}}, w_half};
      F3_LHU:  o_data = {16'd0, w_half};
      default: o_data = i_word;
    endcase
  end

endmodule

// File: rtl/wb_unit.sv
// Writeback stage: accepts one retiring instruction, waits for load data
// when needed, and strikes the register file write port for one cycle.
// Optional retired-instruction counter enabled by WB_RETIRE_CNT_EN.
module wb_unit
  import wb_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  wb_if.slave         bus
`ifdef WB_RETIRE_CNT_EN
  ,
  output logic [31:0] instret
`endif
);

  // Last WAIT_MEM count value before the load is abandoned.
  localparam logic [7:0] LP_CNT_LAST = 8'(MEM_TIMEOUT - 1);

  wb_state_e   r_state;
  wb_state_e   w_state_nxt;
  logic [7:0]  r_cnt;
  logic [7:0]  w_cnt_nxt;
  logic [2:0]  r_funct3;
  logic [1:0]  r_addr_lo;
  logic [4:0]  r_pend_rd;
  logic        r_reg_write;
  logic [4:0]  r_rd_addr;
  logic [31:0] r_rd_data;
  logic        r_load_fault;

  logic        w_commit;
  logic [4:0]  w_commit_rd;
  logic [31:0] w_commit_data;
  logic        w_fault;
  logic        w_load_start;
  logic [31:0] w_sel_val;
  logic [31:0] w_ext;

  load_extract u_ext (
    .i_funct3  (r_funct3),
    .i_addr_lo (r_addr_lo),
    .i_word    (bus.mem_rdata),
    .o_data    (w_ext)
  );

  // Non-load result source mux.
  always_comb begin
    w_sel_val = bus.in_alu_result;
    case (wb_sel_e'(bus.in_wb_sel))
      WB_ALU:  w_sel_val = bus.in_alu_result;
      WB_PC4:  w_sel_val = bus.in_pc_plus4;
      WB_IMM:  w_sel_val = bus.in_imm;
      default: w_sel_val = bus.in_alu_result;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next state plus the commit/fault/latch strobes that feed the output regs.
  // rvalid is tested before the timeout so data arriving on the expiry
  // cycle still commits.
  always_comb begin
    w_state_nxt   = r_state;
    w_commit      = 1'b0;
    w_commit_rd   = r_pend_rd;
    w_commit_data = w_ext;
    w_fault       = 1'b0;
    w_load_start  = 1'b0;
    w_cnt_nxt     = r_cnt;
    case (r_state)
      IDLE: begin
        if (bus.in_valid) begin
          if (bus.in_wb_sel == WB_LOAD) begin
            if (load_ok(bus.in_funct3, bus.in_alu_result[1:0])) begin
              w_load_start = 1'b1;
              w_cnt_nxt    = 8'd0;
              w_state_nxt  = WAIT_MEM;
            end else begin
              w_fault = 1'b1;
            end
          end else begin
            w_commit      = 1'b1;
            w_commit_rd   = bus.in_rd_addr;
            w_commit_data = w_sel_val;
            w_state_nxt   = COMMIT;
          end
        end
      end
      WAIT_MEM: begin
        if (bus.mem_rvalid) begin
          w_commit    = 1'b1;
          w_state_nxt = COMMIT;
        end else if (r_cnt == LP_CNT_LAST) begin
          w_fault     = 1'b1;
          w_state_nxt = IDLE;
        end else begin
          w_cnt_nxt = r_cnt + 8'd1;
        end
      end
      COMMIT:  w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Pending-load context and timeout counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt     <= 8'd0;
      r_funct3  <= 3'd0;
      r_addr_lo <= 2'd0;
      r_pend_rd <= 5'd0;
    end else begin
      r_cnt <= w_cnt_nxt;
      if (w_load_start) begin
        r_funct3  <= bus.in_funct3;
        r_addr_lo <= bus.in_alu_result[1:0];
        r_pend_rd <= bus.in_rd_addr;
      end
    end
  end

  // Registered register-file port: write strike lands in the COMMIT cycle,
  // suppressed for x0; address/data hold between commits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_reg_write  <= 1'b0;
      r_rd_addr    <= 5'd0;
      r_rd_data    <= 32'd0;
      r_load_fault <= 1'b0;
    end else begin
      r_reg_write  <= w_commit && (w_commit_rd != 5'd0);
      r_load_fault <= w_fault;
      if (w_commit) begin
        r_rd_addr <= w_commit_rd;
        r_rd_data <= w_commit_data;
      end
    end
  end

  assign bus.in_ready   = (r_state == IDLE);
  assign bus.reg_write  = r_reg_write;
  assign bus.rd_addr    = r_rd_addr;
  assign bus.rd_data    = r_rd_data;
  assign bus.load_fault = r_load_fault;

`ifdef WB_RETIRE_CNT_EN
  logic [31:0] r_instret;

  // Retired count: one per COMMIT cycle, x0 included, wraps naturally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                 r_instret <= 32'd0;
    else if (r_state == COMMIT) r_instret <= r_instret + 32'd1;
  end

  assign instret = r_instret;
`endif

endmodule

// File: tb/tb_wb_unit.sv
// Self-checking bench for wb_unit: directed cases plus randomized
// instructions checked against a behavioural model of the load rules.
module tb_wb_unit;

  localparam int TMO = 4;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  wb_if u_if ();

`ifdef WB_RETIRE_CNT_EN
  logic [31:0] instret;
`endif

  wb_unit #(.MEM_TIMEOUT(TMO)) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (u_if)
`ifdef WB_RETIRE_CNT_EN
    ,
    .instret (instret)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic bit m_aligned(input logic [2:0] f3, input logic [31:0] addr);
    int size;
    if (!(f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5)) return 1'b0;
    size = 1 << f3[1:0];
    return (addr % size) == 0;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] addr,
                                         input logic [31:0] word);
    int bits, shift;
    logic [31:0] v, mask;
    bits  = 8 << f3[1:0];
    if (bits == 32) return word;
    shift = (addr % 4) / (bits / 8) * bits;
    mask  = (32'd1 << bits) - 32'd1;
    v     = (word >> shift) & mask;
    if (!f3[2] && v[bits-1]) v = v - (32'd1 << bits);
    return v;
  endfunction

  // ---------------- scenario drivers with inline checks ----------------
  task automatic do_nonload(input logic [1:0] sel, input logic [4:0] rd, input logic [31:0] alu,
                            input logic [31:0] pc4, input logic [31:0] imm, input logic [31:0] exp);
    @(negedge clk);
    u_if.in_valid = 1'b1; u_if.in_wb_sel = sel; u_if.in_rd_addr = rd;
    u_if.in_funct3 = 3'($urandom); u_if.in_alu_result = alu;
    u_if.in_pc_plus4 = pc4; u_if.in_imm = imm;
    u_if.mem_rvalid = 1'($urandom); u_if.mem_rdata = $urandom;
    @(negedge clk);
    u_if.in_valid = 1'b0; u_if.mem_rvalid = 1'b0;
    checks++;
    if (u_if.reg_write !== (rd != 5'd0)) begin
      failures++; $display("FAIL nonload_we: got %b want %b (rd=%0d)", u_if.reg_write, rd != 5'd0, rd);
    end
    if (rd != 5'd0) begin
      checks++;
      if (u_if.rd_addr !== rd || u_if.rd_data !== exp) begin
        failures++;
        $display("FAIL nonload_data: got rd=%0d data=%h want rd=%0d data=%h", u_if.rd_addr, u_if.rd_data, rd, exp);
      end
    end
    checks++;
    if (u_if.in_ready !== 1'b0 || u_if.load_fault !== 1'b0) begin
      failures++; $display("FAIL nonload_commit_state: ready=%b fault=%b want 0 0", u_if.in_ready, u_if.load_fault);
    end
    @(negedge clk);
    checks++;
    if (u_if.reg_write !== 1'b0 || u_if.in_ready !== 1'b1) begin
      failures++; $display("FAIL nonload_after: we=%b ready=%b want 0 1", u_if.reg_write, u_if.in_ready);
    end
  endtask

  task automatic do_load(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] rdata,
                         input int lat, input logic [4:0] rd, input bit exp_fault,
                         input logic [31:0] exp, input bit noise);
    bit got;
    @(negedge clk);
    u_if.in_valid = 1'b1; u_if.in_wb_sel = 2'd1; u_if.in_rd_addr = rd; u_if.in_funct3 = f3;
    u_if.in_alu_result = addr; u_if.in_pc_plus4 = $urandom; u_if.in_imm = $urandom;
    @(negedge clk);
    if (exp_fault) begin
      u_if.in_valid = 1'b0;
      checks++;
      if (u_if.load_fault !== 1'b1 || u_if.reg_write !== 1'b0 || u_if.in_ready !== 1'b1) begin
        failures++;
        $display("FAIL misalign: fault=%b we=%b ready=%b want 1 0 1", u_if.load_fault, u_if.reg_write, u_if.in_ready);
      end
      @(negedge clk);
      checks++;
      if (u_if.load_fault !== 1'b0 || u_if.reg_write !== 1'b0) begin
        failures++; $display("FAIL misalign_pulse: fault=%b we=%b want 0 0", u_if.load_fault, u_if.reg_write);
      end
      return;
    end
    got = 1'b0;
    for (int c = 1; c <= TMO; c++) begin
      if (c > 1) @(negedge clk);
      u_if.in_valid = noise;
      if (noise) begin
        u_if.in_wb_sel = 2'd0; u_if.in_rd_addr = 5'($urandom); u_if.in_alu_result = $urandom;
      end
      checks++;
      if (u_if.in_ready !== 1'b0 || u_if.reg_write !== 1'b0 || u_if.load_fault !== 1'b0) begin
        failures++;
        $display("FAIL wait_mem c=%0d: ready=%b we=%b fault=%b want 0 0 0", c, u_if.in_ready, u_if.reg_write, u_if.load_fault);
      end
      if (c == lat + 1) begin
        u_if.mem_rvalid = 1'b1; u_if.mem_rdata = rdata; got = 1'b1;
        break;
      end
    end
    @(negedge clk);
    u_if.mem_rvalid = 1'b0; u_if.in_valid = 1'b0;
    if (got) begin
      checks++;
      if (u_if.reg_write !== (rd != 5'd0) || u_if.load_fault !== 1'b0) begin
        failures++; $display("FAIL load_we: we=%b fault=%b want %b 0", u_if.reg_write, u_if.load_fault, rd != 5'd0);
      end
      if (rd != 5'd0) begin
        checks++;
        if (u_if.rd_addr !== rd || u_if.rd_data !== exp) begin
          failures++;
          $display("FAIL load_data f3=%0d addr=%h: got rd=%0d data=%h want rd=%0d data=%h",
                   f3, addr, u_if.rd_addr, u_if.rd_data, rd, exp);
        end
      end
    end else begin
      checks++;
      if (u_if.load_fault !== 1'b1 || u_if.reg_write !== 1'b0 || u_if.in_ready !== 1'b1) begin
        failures++;
        $display("FAIL timeout: fault=%b we=%b ready=%b want 1 0 1", u_if.load_fault, u_if.reg_write, u_if.in_ready);
      end
      u_if.mem_rvalid = 1'b1; u_if.mem_rdata = rdata;  // late data, must be ignored
    end
    @(negedge clk);
    u_if.mem_rvalid = 1'b0;
    checks++;
    if (u_if.reg_write !== 1'b0 || u_if.load_fault !== 1'b0 || u_if.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL load_after: we=%b fault=%b ready=%b want 0 0 1", u_if.reg_write, u_if.load_fault, u_if.in_ready);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (u_if.reg_write !== 1'b0 || u_if.rd_addr !== 5'd0 || u_if.rd_data !== 32'd0 || u_if.load_fault !== 1'b0) begin
      failures++;
      $display("FAIL reset_vals: we=%b rd=%0d data=%h fault=%b want all 0",
               u_if.reg_write, u_if.rd_addr, u_if.rd_data, u_if.load_fault);
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (u_if.in_ready !== 1'b1) begin
      failures++; $display("FAIL reset_ready: got %b want 1", u_if.in_ready);
    end
  endtask

  task automatic test_alu;
    do_nonload(2'd0, 5'd5, 32'h1234_5678, 32'h0, 32'h0, 32'h1234_5678);
    @(negedge clk);
    checks++;
    if (u_if.rd_addr !== 5'd5 || u_if.rd_data !== 32'h1234_5678) begin
      failures++; $display("FAIL alu_hold: rd=%0d data=%h want 5 12345678", u_if.rd_addr, u_if.rd_data);
    end
    do_nonload(2'd3, 5'd9, 32'h1, 32'h2, 32'hABCD_E000, 32'hABCD_E000);
    do_nonload(2'd2, 5'd1, 32'h1, 32'h0000_1004, 32'h3, 32'h0000_1004);
  endtask

  task automatic test_loads;
    do_load(3'b000, 32'h1003, 32'h80FF_7F01, 1, 5'd7,  1'b0, 32'hFFFF_FF80, 1'b0);
    do_load(3'b100, 32'h1003, 32'h80FF_7F01, 0, 5'd8,  1'b0, 32'h0000_0080, 1'b1);
    do_load(3'b001, 32'h2002, 32'h8001_1234, 2, 5'd10, 1'b0, 32'hFFFF_8001, 1'b0);
    do_load(3'b101, 32'h2002, 32'h8001_1234, 0, 5'd11, 1'b0, 32'h0000_8001, 1'b0);
    do_load(3'b010, 32'h3000, 32'hDEAD_BEEF, TMO - 1, 5'd12, 1'b0, 32'hDEAD_BEEF, 1'b1);
  endtask

  task automatic test_misaligned_x0;
    do_load(3'b010, 32'h4001, 32'h0, 0, 5'd3, 1'b1, 32'h0, 1'b0);
    do_load(3'b101, 32'h4003, 32'h0, 0, 5'd3, 1'b1, 32'h0, 1'b0);
    do_load(3'b011, 32'h4000, 32'h0, 0, 5'd3, 1'b1, 32'h0, 1'b0);
    do_nonload(2'd2, 5'd0, 32'h0, 32'h0000_2004, 32'h0, 32'h0000_2004);
  endtask

  task automatic test_timeout;
    do_load(3'b010, 32'h5000, 32'h1111_2222, TMO, 5'd13, 1'b0, 32'h0, 1'b0);
    do_load(3'b000, 32'h5001, 32'h3333_4444, TMO + 3, 5'd14, 1'b0, 32'h0, 1'b1);
  endtask

  task automatic test_reset_midload;
    @(negedge clk);
    u_if.in_valid = 1'b1; u_if.in_wb_sel = 2'd1; u_if.in_rd_addr = 5'd20;
    u_if.in_funct3 = 3'b010; u_if.in_alu_result = 32'h6000;
    @(negedge clk);
    u_if.in_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if (u_if.reg_write !== 1'b0 || u_if.rd_addr !== 5'd0 || u_if.rd_data !== 32'd0 ||
        u_if.load_fault !== 1'b0 || u_if.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_midload: we=%b rd=%0d data=%h fault=%b ready=%b want 0 0 0 0 1",
               u_if.reg_write, u_if.rd_addr, u_if.rd_data, u_if.load_fault, u_if.in_ready);
    end
    @(negedge clk);
    reset = 1'b0;
    u_if.mem_rvalid = 1'b1; u_if.mem_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    u_if.mem_rvalid = 1'b0;
    checks++;
    if (u_if.reg_write !== 1'b0 || u_if.rd_data !== 32'd0) begin
      failures++; $display("FAIL reset_nocommit: we=%b data=%h want 0 0", u_if.reg_write, u_if.rd_data);
    end
  endtask

  task automatic test_random;
    logic [1:0]  sel;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic [31:0] a, p, im, w, exp;
    int          lat;
    for (int n = 0; n < 60; n++) begin
      sel = 2'($urandom); rd = 5'($urandom); a = $urandom; p = $urandom; im = $urandom;
      if (sel == 2'd1) begin
        f3 = 3'($urandom); w = $urandom; lat = $urandom_range(0, TMO + 1);
        do_load(f3, a, w, lat, rd, !m_aligned(f3, a), m_load(f3, a, w), 1'($urandom));
      end else begin
        exp = (sel == 2'd0) ? a : (sel == 2'd2) ? p : im;
        do_nonload(sel, rd, a, p, im, exp);
      end
    end
  endtask

`ifdef WB_RETIRE_CNT_EN
  task automatic test_instret;
    test_reset();
    do_nonload(2'd0, 5'd3, 32'h5, 32'h0, 32'h0, 32'h5);
    do_nonload(2'd3, 5'd0, 32'h0, 32'h0, 32'h7, 32'h7);
    do_load(3'b010, 32'h7000, 32'h0000_0042, 1, 5'd4, 1'b0, 32'h0000_0042, 1'b0);
    do_load(3'b010, 32'h7002, 32'h0, 0, 5'd4, 1'b1, 32'h0, 1'b0);
    checks++;
    if (instret !== 32'd3) begin
      failures++; $display("FAIL instret: got %0d want 3", instret);
    end
  endtask
`endif

  initial begin
    checks = 0; failures = 0;
    reset = 1'b1;
    u_if.in_valid = 1'b0; u_if.in_rd_addr = 5'd0; u_if.in_wb_sel = 2'd0; u_if.in_funct3 = 3'd0;
    u_if.in_alu_result = 32'd0; u_if.in_pc_plus4 = 32'd0; u_if.in_imm = 32'd0;
    u_if.mem_rvalid = 1'b0; u_if.mem_rdata = 32'd0;
    test_reset();
    test_alu();
    test_loads();
    test_misaligned_x0();
    test_timeout();
    test_reset_midload();
    test_random();
`ifdef WB_RETIRE_CNT_EN
    test_instret();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
